// File: rtl/bias_activation_stage.sv
// -----------------------------------------------------------------------------
// bias_activation_stage
//
// This stage follows matrix_dot_product. It captures one M x N signed
// fixed-point result matrix together with one bias value per column. It adds
// the column bias to each element, saturates the sum back to DW bits and
// applies ReLU. The activated elements stream out in row-major order, one
// element per out_valid/out_ready handshake.
//
// The stage holds a single frame buffer and does not overlap frames. A new
// frame is accepted only while the stage is IDLE. Because of this, one frame
// takes at least M*N+1 cycles.
//
// Optional feature: define LEAKY_RELU_EN to replace plain ReLU with leaky
// ReLU. With leaky ReLU a negative sum is arithmetically shifted right by
// LEAK_SHIFT instead of being forced to zero. FRAC is informational only,
// because the arithmetic does not depend on where the binary point sits.
// -----------------------------------------------------------------------------
module bias_activation_stage #(
    parameter int M          = 2,
    parameter int N          = 2,
    parameter int DW         = 16,
    parameter int FRAC       = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [M*N*DW-1:0]                          in_data,
    input  logic [N*DW-1:0]                            in_bias,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [DW-1:0]                              out_data,
    output logic [((M*N > 1) ? $clog2(M*N) : 1)-1:0]   out_idx,
    output logic                                       out_last
);

    // Width of the element index and of the column counter (minimum 1 bit).
    localparam int IW   = (M * N > 1) ? $clog2(M * N) : 1;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int LAST = M * N - 1;

    // Reject configurations that cannot work. The frame must be non-empty,
    // the shift must leave at least the sign bit, and the binary point must
    // lie inside the word.
    if (M < 1 || N < 1 || DW < 2 || FRAC < 0 || FRAC > DW ||
        LEAK_SHIFT < 0 || LEAK_SHIFT >= DW) begin : g_param_check
        $error("bias_activation_stage: illegal parameter set");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state;
    logic [M*N*DW-1:0]   frame_q;
    logic [N*DW-1:0]     bias_q;
    logic [CW-1:0]       col_q;

    logic [IW-1:0]       next_idx;
    logic [CW-1:0]       next_col;
    logic [DW-1:0]       next_elem;
    logic [DW-1:0]       next_bias;
    logic [DW-1:0]       next_act;
    logic [DW-1:0]       first_act;
    logic                accept;
    logic                transfer;

    // Bias add in DW+1 bits, saturation back to DW bits, then the activation.
    function automatic logic [DW-1:0] bias_act(input logic [DW-1:0] elem,
                                               input logic [DW-1:0] bias);
        logic [DW:0]   sum;
        logic [DW-1:0] sat;
`ifdef LEAKY_RELU_EN
        logic signed [DW-1:0] leak;
`endif
        // NOTE: function locals are ordinary variables evaluated in order, so
        // blocking '=' is correct here. Only state registers use '<='.
        sum = {elem[DW-1], elem} + {bias[DW-1], bias};
        // The sum overflowed when its two top bits disagree. The top bit then
        // holds the true sign, which selects the saturation direction.
        if (sum[DW] != sum[DW-1]) begin
            sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            sat = sum[DW-1:0];
        end
`ifdef LEAKY_RELU_EN
        // The shift is kept in a signed variable of its own. If it sat inside
        // the unsigned ?: below, it would degrade to a logical shift.
        leak     = $signed(sat) >>> LEAK_SHIFT;
        bias_act = sat[DW-1] ? leak : sat;
`else
        bias_act = sat[DW-1] ? '0 : sat;
`endif
    endfunction

    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;

    // Select and activate the element that follows the one currently shown.
    always_comb begin
        next_idx  = out_idx + 1'b1;
        next_col  = (col_q == CW'(N - 1)) ? '0 : col_q + 1'b1;
        next_elem = frame_q[int'(next_idx) * DW +: DW];
        next_bias = bias_q[int'(next_col) * DW +: DW];
        next_act  = bias_act(next_elem, next_bias);
        // Element 0 is computed straight from the inputs, so it appears the
        // cycle after accept without first waiting for the frame registers.
        first_act = bias_act(in_data[DW-1:0], in_bias[DW-1:0]);
    end

    // Frame FSM: capture on accept, then step through elements on each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the frame and bias buffers are reset together with the control
        // state, so a dropped partial frame leaves no stale data behind.
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            col_q     <= '0;
            frame_q   <= '0;
            bias_q    <= '0;
        end else begin
            // NOTE: every assignment to state uses '<='. Each branch then
            // reads the pre-edge values, whatever order the statements are in.
            case (state)
                IDLE: begin
                    if (accept) begin
                        frame_q   <= in_data;
                        bias_q    <= in_bias;
                        out_data  <= first_act;
                        out_idx   <= '0;
                        col_q     <= '0;
                        out_last  <= (LAST == 0);
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (transfer) begin
                        if (out_last) begin
                            // Index and last flag are left as they are. They
                            // mean nothing while out_valid is low.
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            out_data <= next_act;
                            out_idx  <= next_idx;
                            col_q    <= next_col;
                            out_last <= (next_idx == IW'(LAST));
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Protocol invariants of this stage.
    a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(out_data)
                                 && $stable(out_idx) && $stable(out_last));

    a_last_matches_idx: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (out_last == (out_idx == IW'(LAST))));

    a_idx_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (int'(out_idx) <= LAST));

endmodule

// File: tb/tb_bias_activation_stage.sv
// -----------------------------------------------------------------------------
// tb_bias_activation_stage
//
// The stimulus is a set of directed frames whose expected outputs were worked
// out by hand. The stimulus process pushes each expected element into a
// queue. A separate monitor pops from the queue and compares on every output
// transfer. The monitor also checks that outputs hold steady during stalls
// and that in_ready stays low while the stage is streaming.
// -----------------------------------------------------------------------------
module tb_bias_activation_stage;

    localparam int M  = 2;
    localparam int N  = 2;
    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    idx;
        logic          last;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [M*N*DW-1:0] in_data;
    logic [N*DW-1:0]   in_bias;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_idx;
    logic              out_last;

    exp_t sb[$];
    int   total;
    int   bad;
    int   xfers;
    logic bp_mode;
    int   bp_ph;
    logic [3:0] bp_pat;

    // Monitor state used for the stall-stability check.
    logic          stalled;
    logic [DW-1:0] held_data;
    logic [1:0]    held_idx;
    logic          held_last;

`ifdef LEAKY_RELU_EN
    localparam logic [15:0] F2_E0  = 16'hFFE0;
    localparam logic [15:0] SAT_E1 = 16'hF000;
    localparam logic [15:0] SAT_E3 = 16'hFFE0;
`else
    localparam logic [15:0] F2_E0  = 16'h0000;
    localparam logic [15:0] SAT_E1 = 16'h0000;
    localparam logic [15:0] SAT_E3 = 16'h0000;
`endif

    bias_activation_stage #(
        .M(M), .N(N), .DW(DW), .FRAC(8), .LEAK_SHIFT(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Consumer: always ready, or the repeating pattern 1,0,0,1 when backpressure is on.
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            out_ready = bp_pat[bp_ph];
            bp_ph     = (bp_ph + 1) % 4;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: sample halfway between edges and score every transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (out_valid) check("in_ready_low_in_stream", {31'b0, in_ready}, 32'd0);
            if (stalled) begin
                check("stall_valid_held", {31'b0, out_valid}, 32'd1);
                check("stall_data_stable", {16'b0, out_data}, {16'b0, held_data});
                check("stall_idx_stable", {30'b0, out_idx}, {30'b0, held_idx});
                check("stall_last_stable", {31'b0, out_last}, {31'b0, held_last});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output_idx", {30'b0, out_idx}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", {16'b0, out_data}, {16'b0, e.data});
                    check("out_idx", {30'b0, out_idx}, {30'b0, e.idx});
                    check("out_last", {31'b0, out_last}, {31'b0, e.last});
                end
                xfers++;
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_idx  = out_idx;
            held_last = out_last;
        end
    end

    // Queue a frame's four expected outputs, then present the frame until it is accepted.
    task automatic send_frame(input logic [63:0] d, input logic [31:0] b,
                              input logic [63:0] exp, input logic hold);
        logic ready;
        logic accepted;
        int   n;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.data = exp[k*16 +: 16];
            e.idx  = 2'(k);
            e.last = (k == 3);
            sb.push_back(e);
        end
        in_data  = d;
        in_bias  = b;
        in_valid = 1'b1;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 50) begin
            ready = in_ready;
            @(posedge clk);
            #1;
            accepted = ready;
            n++;
        end
        check("frame_accepted", {31'b0, accepted}, 32'd1);
        check("valid_one_cycle_after_accept", {31'b0, out_valid}, 32'd1);
        check("first_idx_zero", {30'b0, out_idx}, 32'd0);
        if (!hold) in_valid = 1'b0;
    endtask

    // Wait until every queued element has been seen and the stage is idle again.
    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_remaining", sb.size(), 32'd0);
        check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int n;
        int x0;
        total     = 0;
        bad       = 0;
        xfers     = 0;
        bp_mode   = 1'b0;
        bp_ph     = 0;
        bp_pat    = 4'b1001;
        stalled   = 1'b0;
        held_data = '0;
        held_idx  = '0;
        held_last = 1'b0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bias   = '0;
        out_ready = 1'b1;

        // Asynchronous reset, asserted between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {16'b0, out_data}, 32'd0);
        check("rst_out_idx", {30'b0, out_idx}, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame: {7,10,15,22} with bias {-8, 0.5}.
        send_frame(64'h1600_0F00_0A00_0700, 32'h0080_F800,
                   {16'h1680, 16'h0700, 16'h0A80, F2_E0}, 1'b0);
        wait_idle();

        // Saturation at both ends.
        send_frame(64'h0000_0100_8000_7F00, 32'hFF00_0100,
                   {SAT_E3, 16'h0200, SAT_E1, 16'h7FFF}, 1'b0);
        wait_idle();

        // Backpressure with the consumer pattern 1,0,0,1.
        bp_ph   = 0;
        bp_mode = 1'b1;
        send_frame(64'h0004_0003_0002_0001, 32'h0000_0000,
                   {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b0);
        wait_idle();
        bp_mode = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back frames. in_valid stays high and the inputs switch to
        // frame B while frame A is still streaming.
        send_frame(64'h1600_0F00_0A00_0700, 32'h0080_F800,
                   {16'h1680, 16'h0700, 16'h0A80, F2_E0}, 1'b1);
        in_data = 64'h0005_0020_FFF0_0010;
        in_bias = 32'h0010_0000;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            logic [63:0] eb;
            eb     = {16'h0015, 16'h0020, 16'h0000, 16'h0010};
            e.data = eb[k*16 +: 16];
            e.idx  = 2'(k);
            e.last = (k == 3);
            sb.push_back(e);
        end
        n = 0;
        while (!(out_valid && out_last) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_reached_last", {31'b0, out_last}, 32'd1);
        @(posedge clk);
        #1;
        check("b2b_not_accepted_on_last", {31'b0, out_valid}, 32'd0);
        check("b2b_ready_after_last", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("b2b_accepted_next_cycle", {31'b0, out_valid}, 32'd1);
        check("b2b_second_idx_zero", {30'b0, out_idx}, 32'd0);
        in_valid = 1'b0;
        wait_idle();

        // Reset mid-frame after two transfers.
        x0 = xfers;
        send_frame(64'h4000_3000_2000_1000, 32'h0000_0000,
                   {16'h4000, 16'h3000, 16'h2000, 16'h1000}, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_reset_two_transfers", xfers - x0, 32'd2);
        sb.delete();
        rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", {31'b0, out_valid}, 32'd0);
        send_frame(64'h1600_0F00_0A00_0700, 32'h0080_F800,
                   {16'h1680, 16'h0700, 16'h0A80, F2_E0}, 1'b0);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
